pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_if.sv | 40 ++++
 rtl/pc_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pc_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: fetch-control bus between the execute stage / instruction
// memory side (master) and the PC controller (slave).
interface pc_ctrl_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        imem_ready_i;
    logic [31:0] pc_o;
    logic        inst_req_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        hold_o;
    logic        misalign_o;

    modport slave (
        input  jump_en_i,
        input  jump_addr_i,
        input  hold_flag_i,
        input  imem_ready_i,
        output pc_o,
        output inst_req_o,
        output flush_if_id_o,
        output flush_id_ex_o,
        output hold_o,
        output misalign_o
    );

    modport master (
        output jump_en_i,
        output jump_addr_i,
        output hold_flag_i,
        output imem_ready_i,
        input  pc_o,
        input  inst_req_o,
        input  flush_if_id_o,
        input  flush_id_ex_o,
        input  hold_o,
        input  misalign_o
    );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter / fetch controller.
// Sequences BOOT -> RUN, squashes fetch for FLUSH_CYCLES cycles after a
// redirect, freezes the front end on hold requests.
// Optional feature macro JUMP_ALIGN_CHECK_EN: a redirect to a non-word-aligned
// target enters a TRAP state (left only by reset) and sets sticky misalign_o.
// Without the macro the target's low two bits are cleared and misalign_o is 0.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_ctrl_if.slave   bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_HOLD  = 3'd3
`ifdef JUMP_ALIGN_CHECK_EN
        ,
        ST_TRAP  = 3'd4
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        w_inst_req;
    logic        w_flush_if_id;
    logic        w_flush_id_ex;
    logic        w_hold;
    logic        w_jump_take;
    logic [31:0] w_jump_tgt;
    logic        w_jump_bad;

`ifdef JUMP_ALIGN_CHECK_EN
    logic        r_misalign;
    logic        w_misalign_nxt;

    // Redirects are honoured everywhere except TRAP; the target is used as-is.
    assign w_jump_take = bus.jump_en_i && (r_state != ST_TRAP);
    assign w_jump_tgt  = bus.jump_addr_i;
    assign w_jump_bad  = (bus.jump_addr_i[1:0] != 2'b00);
`else
    // Redirects are honoured in every state; the target is forced word-aligned.
    assign w_jump_take = bus.jump_en_i;
    assign w_jump_tgt  = bus.jump_addr_i & 32'hFFFF_FFFC;
    assign w_jump_bad  = 1'b0;
`endif

    // Next-state, next-PC, squash counter and per-cycle output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        w_inst_req    = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_hold        = 1'b0;
`ifdef JUMP_ALIGN_CHECK_EN
        w_misalign_nxt = r_misalign;
`endif

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_inst_req = 1'b1;
                if (bus.hold_flag_i) begin
                    w_state_nxt = ST_HOLD;
                end else if (bus.imem_ready_i) begin
                    w_pc_nxt = r_pc + 32'd4;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_FLUSH: begin
                // hold_flag_i is deliberately ignored until the squash completes
                w_flush_if_id = 1'b1;
                w_cnt_nxt     = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_HOLD: begin
                w_hold        = 1'b1;
                w_flush_id_ex = 1'b1;
                if (!bus.hold_flag_i) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
`ifdef JUMP_ALIGN_CHECK_EN
            ST_TRAP: begin
                w_hold        = 1'b1;
                w_flush_id_ex = 1'b1;
                w_state_nxt   = ST_TRAP;
            end
`endif
            default: begin
                w_state_nxt = ST_BOOT;
                w_pc_nxt    = RESET_PC;
                w_cnt_nxt   = 3'd0;
            end
        endcase

        // A redirect outranks hold and fetch progress in every live state;
        // the newest redirect always reloads the target and counter.
        if (w_jump_take) begin
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            w_pc_nxt      = w_jump_tgt;
            w_cnt_nxt     = FLUSH_LOAD;
            if (w_jump_bad) begin
`ifdef JUMP_ALIGN_CHECK_EN
                w_state_nxt    = ST_TRAP;
                w_misalign_nxt = 1'b1;
`else
                w_state_nxt    = ST_FLUSH;
`endif
            end else begin
                w_state_nxt = ST_FLUSH;
            end
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end

        // While reset is held the pipeline is kept flushed and fetch is off.
        if (!rst_n) begin
            w_inst_req    = 1'b0;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            w_hold        = 1'b0;
        end else begin
            w_hold = w_hold;
        end
    end

    // State, PC and squash-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef JUMP_ALIGN_CHECK_EN
    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end

    assign bus.misalign_o = r_misalign;
`else
    assign bus.misalign_o = 1'b0;
`endif

    assign bus.pc_o          = r_pc;
    assign bus.inst_req_o    = w_inst_req;
    assign bus.flush_if_id_o = w_flush_if_id;
    assign bus.flush_id_ex_o = w_flush_id_ex;
    assign bus.hold_o        = w_hold;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed self-checking bench for pc_ctrl (RESET_PC=0,
// FLUSH_CYCLES=2). Inputs change 1 time unit after the rising edge,
// outputs are checked 2 time units after it.
module tb_pc_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pc_ctrl_if bus ();

    pc_ctrl #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus and checks.
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.jump_en_i    = 1'b0;
        bus.jump_addr_i  = 32'h0;
        bus.hold_flag_i  = 1'b0;
        bus.imem_ready_i = 1'b1;

        // Reset held
        tick(); tick();
        #1;
        chk("rst_pc",       bus.pc_o,          32'h0);
        chk("rst_req",      bus.inst_req_o,    32'h0);
        chk("rst_fifid",    bus.flush_if_id_o, 32'h1);
        chk("rst_fidex",    bus.flush_id_ex_o, 32'h1);
        chk("rst_hold",     bus.hold_o,        32'h0);
        chk("rst_misalign", bus.misalign_o,    32'h0);

        // Release: one BOOT cycle
        tick();
        rst_n = 1'b1;
        #1;
        chk("boot_req",   bus.inst_req_o,    32'h0);
        chk("boot_pc",    bus.pc_o,          32'h0);
        chk("boot_fifid", bus.flush_if_id_o, 32'h0);

        // Sequential fetch 0,4,8
        tick(); #1;
        chk("run_req0", bus.inst_req_o, 32'h1);
        chk("run_pc0",  bus.pc_o,       32'h0);
        tick(); #1;
        chk("run_pc4",  bus.pc_o,       32'h4);
        tick(); #1;
        chk("run_pc8",  bus.pc_o,       32'h8);

        // Redirect at pc=8 to 0x100
        bus.jump_en_i   = 1'b1;
        bus.jump_addr_i = 32'h100;
        #1;
        chk("jmp_fifid", bus.flush_if_id_o, 32'h1);
        chk("jmp_fidex", bus.flush_id_ex_o, 32'h1);
        tick();
        bus.jump_en_i = 1'b0;
        #1;
        chk("fl1_pc",    bus.pc_o,          32'h100);
        chk("fl1_req",   bus.inst_req_o,    32'h0);
        chk("fl1_fifid", bus.flush_if_id_o, 32'h1);
        tick(); #1;
        chk("fl2_req",   bus.inst_req_o,    32'h0);
        chk("fl2_pc",    bus.pc_o,          32'h100);
        tick(); #1;
        chk("tgt_req",   bus.inst_req_o,    32'h1);
        chk("tgt_pc",    bus.pc_o,          32'h100);
        tick(); #1;
        chk("tgt_pc4",   bus.pc_o,          32'h104);

        // imem not ready: pc holds
        bus.imem_ready_i = 1'b0;
        tick(); #1;
        chk("stall_pc",  bus.pc_o,          32'h104);
        bus.imem_ready_i = 1'b1;

        // Redirect to 0x10 then hold 3 cycles
        bus.jump_en_i   = 1'b1;
        bus.jump_addr_i = 32'h10;
        tick();
        bus.jump_en_i = 1'b0;
        tick(); tick(); #1;
        chk("run10_req", bus.inst_req_o, 32'h1);
        chk("run10_pc",  bus.pc_o,       32'h10);
        bus.hold_flag_i = 1'b1;
        tick(); #1;
        chk("hold1_o",   bus.hold_o,        32'h1);
        chk("hold1_pc",  bus.pc_o,          32'h10);
        chk("hold1_req", bus.inst_req_o,    32'h0);
        chk("hold1_fx",  bus.flush_id_ex_o, 32'h1);
        tick(); #1;
        chk("hold2_o",   bus.hold_o,        32'h1);
        tick();
        bus.hold_flag_i = 1'b0;
        #1;
        chk("hold3_o",   bus.hold_o,        32'h1);
        chk("hold3_pc",  bus.pc_o,          32'h10);
        tick(); #1;
        chk("resume_o",  bus.hold_o,        32'h0);
        chk("resume_req",bus.inst_req_o,    32'h1);
        chk("resume_pc", bus.pc_o,          32'h10);
        tick(); #1;
        chk("resume_pc4",bus.pc_o,          32'h14);

        // Simultaneous jump + hold: jump wins, hold ignored in FLUSH
        bus.jump_en_i   = 1'b1;
        bus.hold_flag_i = 1'b1;
        bus.jump_addr_i = 32'h40;
        #1;
        chk("jh_fidex",  bus.flush_id_ex_o, 32'h1);
        chk("jh_hold",   bus.hold_o,        32'h0);
        tick();
        bus.jump_en_i = 1'b0;
        #1;
        chk("jh_pc",     bus.pc_o,          32'h40);
        chk("jh_fl_hold",bus.hold_o,        32'h0);
        chk("jh_fl_fifid",bus.flush_if_id_o,32'h1);
        tick(); #1;
        chk("jh_fl2_hold",bus.hold_o,       32'h0);
        bus.hold_flag_i = 1'b0;
        tick(); #1;
        chk("jh_run_req",bus.inst_req_o,    32'h1);
        chk("jh_run_pc", bus.pc_o,          32'h40);

        // Redirect during FLUSH: newest wins, counter reloaded
        bus.jump_en_i   = 1'b1;
        bus.jump_addr_i = 32'h200;
        tick(); #1;
        chk("re1_pc",    bus.pc_o,          32'h200);
        bus.jump_addr_i = 32'h300;
        #1;
        chk("re_fidex",  bus.flush_id_ex_o, 32'h1);
        tick();
        bus.jump_en_i = 1'b0;
        #1;
        chk("re2_pc",    bus.pc_o,          32'h300);
        chk("re2_req",   bus.inst_req_o,    32'h0);
        tick(); #1;
        chk("re3_req",   bus.inst_req_o,    32'h0);
        tick(); #1;
        chk("re_run_req",bus.inst_req_o,    32'h1);
        chk("re_run_pc", bus.pc_o,          32'h300);

        // 32-bit wrap
        bus.jump_en_i   = 1'b1;
        bus.jump_addr_i = 32'hFFFF_FFFC;
        tick();
        bus.jump_en_i = 1'b0;
        tick(); tick(); #1;
        chk("wrap_pre",  bus.pc_o,          32'hFFFF_FFFC);
        tick(); #1;
        chk("wrap_pc",   bus.pc_o,          32'h0);

        // Misaligned redirect
        bus.jump_en_i   = 1'b1;
        bus.jump_addr_i = 32'h102;
        #1;
        chk("mis_fifid", bus.flush_if_id_o, 32'h1);
        tick();
        bus.jump_en_i   = 1'b0;
`ifdef JUMP_ALIGN_CHECK_EN
        #1;
        chk("trap_pc",   bus.pc_o,          32'h102);
        chk("trap_mis",  bus.misalign_o,    32'h1);
        bus.hold_flag_i = 1'b0;
        bus.jump_en_i   = 1'b1;
        bus.jump_addr_i = 32'h400;
        tick(); tick(); tick(); #1;
        chk("trap_req",  bus.inst_req_o,    32'h0);
        chk("trap_hold", bus.hold_o,        32'h1);
        chk("trap_pc2",  bus.pc_o,          32'h102);
        chk("trap_mis2", bus.misalign_o,    32'h1);
        bus.jump_en_i   = 1'b0;
`else
        #1;
        chk("mis_pc",    bus.pc_o,          32'h100);
        chk("mis_flag",  bus.misalign_o,    32'h0);
        tick(); tick(); #1;
        chk("mis_req",   bus.inst_req_o,    32'h1);
        chk("mis_run_pc",bus.pc_o,          32'h100);
`endif

        // Reset mid-FLUSH
        bus.jump_en_i   = 1'b1;
        bus.jump_addr_i = 32'h500;
        tick();
        bus.jump_en_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_req",   bus.inst_req_o,    32'h0);
        chk("mrst_fifid", bus.flush_if_id_o, 32'h1);
        chk("mrst_fidex", bus.flush_id_ex_o, 32'h1);
        chk("mrst_hold",  bus.hold_o,        32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_pc",    bus.pc_o,          32'h0);
        chk("mrst_mis",   bus.misalign_o,    32'h0);
        chk("mrst_boot",  bus.inst_req_o,    32'h0);
        tick(); #1;
        chk("mrst_run",   bus.inst_req_o,    32'h1);
        chk("mrst_pc0",   bus.pc_o,          32'h0);
        tick(); #1;
        chk("mrst_pc4",   bus.pc_o,          32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
